// File: rtl/mine_cursor_enc.sv
// mine_cursor_enc: cursor/select front end for the minesweeper datapath.
// It moves a row/column cursor with edge-detected direction buttons. On select
// it encodes the cell index row*GRID_N+col and offers it on a data/valid
// interface.
// Optional feature: define AUTO_REPEAT_EN to make held direction buttons
// auto-repeat every REPEAT_DLY clocks. The default build has no repeat logic.
//
// Handshake: data_valid rises with a new index. data stays stable while
// data_valid=1. A one-cycle ack while data_valid=1 consumes the index, and
// data_valid falls on the following edge. ack with data_valid=0 is ignored.
// data keeps its last value after consumption.
module mine_cursor_enc #(
   parameter int GRID_N = 5,
   parameter int IDX_W  = 5
`ifdef AUTO_REPEAT_EN
   ,
   parameter int REPEAT_DLY = 8
`endif
) (
   input  logic                     clka,
   input  logic                     restart,
   input  logic                     btn_up,
   input  logic                     btn_down,
   input  logic                     btn_left,
   input  logic                     btn_right,
   input  logic                     btn_sel,
   input  logic [GRID_N*GRID_N-1:0] cleared,
   input  logic                     gameover,
   input  logic                     ack,
   output logic [IDX_W-1:0]         data,
   output logic                     data_valid,
   output logic                     reject,
   output logic [2:0]               cursor_row,
   output logic [2:0]               cursor_col,
   output logic [1:0]               state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      LOCK = 2'd2
   } state_t;

   localparam logic [2:0] LAST = 3'(GRID_N - 1);

   state_t     state;
   // Button bit order: {sel, right, left, down, up}.
   logic [4:0] btn_now;
   logic [4:0] btn_q;
   logic [4:0] btn_prev;
   logic [4:0] btn_edge;
   logic [3:0] rpt_pulse;
   logic [3:0] move;
   logic       sel_edge;
   logic [IDX_W-1:0] cur_idx;
   logic       cell_cleared;

   assign btn_now  = {btn_sel, btn_right, btn_left, btn_down, btn_up};
   assign btn_edge = btn_q & ~btn_prev;
   assign sel_edge = btn_edge[4];
   assign move     = btn_edge[3:0] | rpt_pulse;
   assign state_dbg = state;

   // The index is built from the cursor before any move made in the same cycle.
   assign cur_idx      = IDX_W'(cursor_row) * IDX_W'(GRID_N) + IDX_W'(cursor_col);
   assign cell_cleared = cleared[cur_idx];

   // Button sampling and edge history. Both stages clear on restart, so a button held through reset produces one edge afterwards.
   always_ff @(posedge clka) begin
      if (restart) begin
         btn_q    <= '0;
         btn_prev <= '0;
      end else begin
         btn_q    <= btn_now;
         btn_prev <= btn_q;
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int CNT_W = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_DLY - 1);

   logic [CNT_W-1:0] rpt_cnt;
   logic             dir_same;

   assign dir_same  = (btn_q[3:0] == btn_prev[3:0]) && (btn_q[3:0] != 4'd0);
   assign rpt_pulse = (dir_same && rpt_cnt == CNT_LAST) ? btn_q[3:0] : 4'd0;

   // Repeat timer. It restarts whenever the held direction set changes and wraps after each repeat.
   always_ff @(posedge clka) begin
      if (restart || (btn_q[3:0] != btn_prev[3:0])) begin
         rpt_cnt <= '0;
      end else if (dir_same) begin
         if (rpt_cnt == CNT_LAST) rpt_cnt <= '0;
         else                     rpt_cnt <= rpt_cnt + 1'b1;
      end
   end
`else
   assign rpt_pulse = 4'd0;
`endif

   // Cursor update. Opposite directions cancel, and moves off either edge wrap around.
   always_ff @(posedge clka) begin
      if (restart) begin
         cursor_row <= 3'd0;
         cursor_col <= 3'd0;
      end else begin
         if (move[0] && !move[1])
            cursor_row <= (cursor_row == 3'd0) ? LAST : cursor_row - 3'd1;
         else if (move[1] && !move[0])
            cursor_row <= (cursor_row == LAST) ? 3'd0 : cursor_row + 3'd1;
         if (move[2] && !move[3])
            cursor_col <= (cursor_col == 3'd0) ? LAST : cursor_col - 3'd1;
         else if (move[3] && !move[2])
            cursor_col <= (cursor_col == LAST) ? 3'd0 : cursor_col + 3'd1;
      end
   end

   // Select FSM. IDLE accepts or refuses a select, PEND holds the index until ack, and LOCK refuses selects until gameover clears.
   always_ff @(posedge clka) begin
      if (restart) begin
         state      <= IDLE;
         data       <= '0;
         data_valid <= 1'b0;
         reject     <= 1'b0;
      end else begin
         reject <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_edge) begin
                  if (gameover || cell_cleared) begin
                     reject <= 1'b1;
                  end else begin
                     data       <= cur_idx;
                     data_valid <= 1'b1;
                     state      <= PEND;
                  end
               end
            end
            PEND: begin
               if (ack) begin
                  data_valid <= 1'b0;
                  state      <= gameover ? LOCK : IDLE;
               end
            end
            LOCK: begin
               if (sel_edge) reject <= 1'b1;
               if (!gameover) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mine_cursor_enc.md
Name: mine_cursor_enc

Overview:
User-input front end for the minesweeper datapath. Moves a row/column cursor over the GRID_N x GRID_N board using direction buttons. On select, it encodes the cursor position into the 5-bit cell index that the datapath loads and decodes.
It is the producing end of the datapath's data/load interface. It holds each index stable until acknowledged and rejects selections of already-cleared cells or any selection after game over.

Parameters:
GRID_N, 5, board edge length; cells are indexed row*GRID_N+col; index 0 is row 0/col 0 (datapath column 1).
IDX_W, 5, width of the encoded index; GRID_N*GRID_N must be <= 2**IDX_W.
REPEAT_DLY, 8, auto-repeat period in clocks; used only when AUTO_REPEAT_EN is defined.

Ports:
clka  in  1  sole clock; all state updates on its rising edge.
restart  in  1  synchronous, active-high reset.
btn_up  in  1  level, already synchronised; row-1.
btn_down  in  1  level; row+1.
btn_left  in  1  level; col-1.
btn_right  in  1  level; col+1.
btn_sel  in  1  level; request to open the cursor cell.
cleared  in  GRID_N*GRID_N  cleared-cell map from the datapath, bit i = cell i.
gameover  in  1  level from the datapath; locks selection.
ack  in  1  one-cycle pulse; the controller has consumed data.
data  out  IDX_W  encoded cell index; stable while data_valid=1.
data_valid  out  1  index pending.
reject  out  1  one-cycle pulse; the select was refused.
cursor_row  out  3  current row, 0..GRID_N-1.
cursor_col  out  3  current column, 0..GRID_N-1.

Behaviour:
- Reset (restart=1 at a clka edge) has priority over all other inputs in the same cycle:
  - data=0, data_valid=0, reject=0, cursor_row=0, cursor_col=0, state=IDLE.
  - All button edge-history registers cleared to 0, so a button held through reset registers one edge after release of restart.
- Edge detect: each button acts on its 0->1 transition only (registered previous value). One press produces exactly one action.
- Cursor movement:
  - Applied the cycle after the edge; cursor outputs are registered.
  - Wrap-around: up at row 0 -> row GRID_N-1; down at GRID_N-1 -> 0; the same rule applies to left/right on columns.
  - Up and down edges in the same cycle: row unchanged. Left and right in the same cycle: column unchanged.
  - Row and column moves in the same cycle both apply.
  - Movement is legal in every state, including LOCK. The cursor never leaves the 0..GRID_N-1 range.
- State machine:
  - IDLE, on a sel edge:
    - If gameover=1 or cleared[row*GRID_N+col]=1: reject=1 for one cycle, stay in IDLE.
    - Otherwise: data <= row*GRID_N+col (using the cursor value before any same-cycle move), data_valid <= 1, go to PEND.
  - PEND:
    - data and data_valid are held. Further sel edges are ignored; no reject.
    - ack=1 -> data_valid <= 0 next cycle, then go to IDLE if gameover=0, else LOCK.
    - A sel edge in the same cycle as ack is ignored.
  - LOCK: every sel edge pulses reject. Leave LOCK to IDLE when gameover returns to 0.
  - IDLE with gameover=1 behaves the same as LOCK for sel edges.
- ack while data_valid=0: ignored.
- Latency: select edge sampled at edge N -> data_valid high after edge N+1.
- data holds its last value after ack; it does not return to 0.
- Index arithmetic is unsigned with IDX_W-bit result. No overflow is possible under the parameter constraint.

Optional Feature:
AUTO_REPEAT_EN
- Defined:
  - A direction button held continuously generates a further move every REPEAT_DLY clocks after its initial edge.
  - The repeat counter restarts on release, on restart, or when a different direction is pressed.
  - Repeats obey the same wrap and cancel rules as single presses.
  - btn_sel never auto-repeats.
- Not defined: the repeat counter is absent; each press moves the cursor exactly once however long it is held.

Test Plan:
1. Reset with btn_down held -> cursor 0/0, data_valid=0. Release, press down -> row=1. Then left -> col=4 (wrap).
2. Cursor row 2/col 3, cleared=0, gameover=0, sel edge -> data=13 and data_valid=1 after edge N+1. Hold through 3 more sel edges without ack -> data stays 13, no reject. ack -> data_valid=0, state IDLE.
3. cleared bit 7 set, cursor row 1/col 2, sel -> reject pulses exactly 1 cycle, data_valid stays 0.
4. In PEND, assert gameover with ack -> data_valid drops; next sel -> reject. Drop gameover, sel on an uncleared cell -> accepted.
5. Press up+down+right in one cycle from 4/4 -> row 4, col 0. Restart asserted during PEND -> all outputs at reset values next cycle.
6. With AUTO_REPEAT_EN and REPEAT_DLY=8, hold right for 20 cycles from col 0 -> 3 moves total, col=3. Without the macro -> col=1.
